aes_enc_ctrl: RTL and testbench
===============================

// Module: aes_enc_ctrl
// PURPOSE
//  Iterative AES-128 encryption sequencer around one combinational round_tf datapath.
//  - Accepts plaintext + cipher key over a valid/ready handshake.
//  - Runs initial AddRoundKey, then 10 rounds, one per cycle, with an on-the-fly key schedule.
//  - Returns ciphertext over a valid/ready handshake. Sits between the HEA bus front-end and the round datapath.
// PARAMETERS
//  NR        10   number of rounds (AES-128 only; other values unsupported)
//  RST_STATE '0   reset value of the internal state/key registers
// PORTS
//  clk_i       in   1    clock
//  rst_ni      in   1    asynchronous active-low reset
//  in_valid_i  in   1    plaintext/key valid
//  in_ready_o  out  1    block can accept a job (high only in IDLE)
//  pt_i        in   128  plaintext; [127:120] = byte 0 (FIPS-197 order)
//  key_i       in   128  cipher key, same byte order
//  out_valid_o out  1    ciphertext valid
//  out_ready_i in   1    consumer accepts ciphertext
//  ct_o        out  128  ciphertext; held stable while out_valid_o && !out_ready_i
//  busy_o      out  1    high in ROUND or DONE
// BEHAVIOUR
//  - Reset (async assert, sync deassert at clk_i):
//    - FSM=IDLE, state/key regs=RST_STATE, rnd=0.
//    - in_ready_o=1, out_valid_o=0, busy_o=0, ct_o=0.
//  - FSM IDLE -> ROUND -> DONE -> IDLE.
//  - IDLE: on in_valid_i && in_ready_o:
//    - state <= pt_i ^ key_i; rkey <= key_i; rnd <= 1; go to ROUND.
//  - ROUND: each cycle,
//    - nk <= aes_key_step(rkey, RCON[rnd]); rkey <= nk.
//    - rnd<NR: state <= round_tf.b_o ^ nk (SubBytes+ShiftRows+MixColumns).
//    - rnd==NR: state <= round_tf.b_sr_o ^ nk (no MixColumns); go to DONE.
//    - rnd increments 1..NR, 4-bit, never wraps; clears to 0 on entry to DONE.
//  - DONE: out_valid_o=1, ct_o=state.
//    - out_ready_i=1 -> IDLE; ct_o keeps its last value until the next DONE.
//  - Latency: input handshake at cycle 0 -> out_valid_o rises at cycle NR+1 (11).
//    - Throughput is 1 block per 12 cycles with out_ready_i tied high.
//  - in_ready_o is low in ROUND/DONE.
//    - in_valid_i there is ignored; pt_i/key_i are sampled only at the handshake.
//  - out_ready_i outside DONE has no effect.
//  - No back-to-back overlap: IDLE is always visited for one cycle between jobs.
//  - Reset asserted mid-job: job discarded, no partial output, outputs take reset values immediately.
// CONFIGURATION
//  AES_ENC_CTRL_ABORT_EN
//  - Defined: adds port abort_i (in, 1).
//    - abort_i=1 in ROUND or DONE -> next cycle IDLE, out_valid_o=0, state/rkey/rnd cleared to RST_STATE/0.
//    - abort_i has priority over out_ready_i in DONE; ignored in IDLE.
//  - Undefined: no abort_i port; only rst_ni terminates a job.
// STRUCTURE
//  - aes_pkg holds:
//    - AES_NR=10.
//    - RCON[1:10] = 01,02,04,08,10,20,40,80,1b,36.
//    - aes_state_t (128-bit).
//    - FSM enum aes_ctrl_e {IDLE, ROUND, DONE}.
//  - Sub-module aes_key_step (combinational).
//    - Inputs: rkey_i[127:0], rcon_i[7:0]. Output: nkey_o[127:0].
//    - Computes RotWord/SubWord/Rcon XOR plus the 4-word chain.
//    - Uses its own S-box instance.
//  - One round_tf #(.EN_MC(1)) instance: b_i=state.
//    - b_o is the full round output; b_sr_o is the final-round (pre-MixColumns) output.
// TESTING
//  1. FIPS-197 B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c
//     -> ct 3925841d02dc09fbdc118597196a0b32, out_valid_o 11 cycles after handshake.
//  2. FIPS-197 C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f
//     -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//  3. Backpressure: out_ready_i=0 for 5 cycles in DONE
//     -> ct_o/out_valid_o stable, in_ready_o=0; release -> IDLE next cycle.
//  4. in_valid_i held high with changing pt_i during ROUND
//     -> ignored; result equals the vector sampled at the handshake.
//  5. rst_ni pulsed low at round 5
//     -> out_valid_o=0, in_ready_o=1 immediately; next job (vector 1) correct.
//  6. (ABORT_EN) abort_i at round 3
//     -> IDLE next cycle, no out_valid_o; following job correct.

Source files
------------

// File: rtl/aes_enc_ctrl_pkg.sv
// Shared AES-128 definitions for the iterative encryption sequencer.
//   AES_NR      : number of rounds for AES-128
//   aes_state_t : 128-bit state/key word; byte 0 sits in [127:120]
//   aes_ctrl_e  : sequencer FSM states
//   rcon()      : round constant for rounds 1..10
//   sbox()      : forward S-box lookup
//   xtime()     : multiply by x in GF(2^8)
package aes_enc_ctrl_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_ctrl_e;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_enc_ctrl_if.sv
// Job/result handshake bundle of the AES encryption sequencer.
//   in_valid_i/in_ready_o : plaintext + key handshake (pt_i, key_i)
//   out_valid_o/out_ready_i : ciphertext handshake (ct_o)
//   busy_o                : sequencer is working on or holding a job
// master = job producer / result consumer, slave = the sequencer.
interface aes_enc_ctrl_if;
    import aes_enc_ctrl_pkg::*;

    logic       in_valid_i;
    logic       in_ready_o;
    aes_state_t pt_i;
    aes_state_t key_i;
    logic       out_valid_o;
    logic       out_ready_i;
    aes_state_t ct_o;
    logic       busy_o;

    modport master (
        output in_valid_i, pt_i, key_i, out_ready_i,
        input  in_ready_o, out_valid_o, ct_o, busy_o
    );

    modport slave (
        input  in_valid_i, pt_i, key_i, out_ready_i,
        output in_ready_o, out_valid_o, ct_o, busy_o
    );
endinterface

// File: rtl/aes_key_step.sv
// One step of the AES-128 key expansion (combinational).
//   rkey_i : current round key, word 0 in [127:96]
//   rcon_i : round constant for the key being produced
//   nkey_o : next round key
module aes_key_step
    import aes_enc_ctrl_pkg::*;
(
    input  aes_state_t rkey_i,
    input  logic [7:0] rcon_i,
    output aes_state_t nkey_o
);

    logic [31:0] w [4];
    logic [31:0] n [4];
    logic [31:0] rot;
    logic [31:0] temp;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_words
            assign w[gi] = rkey_i[127 - 32 * gi -: 32];
            assign nkey_o[127 - 32 * gi -: 32] = n[gi];
        end
    endgenerate

    assign rot = {w[3][23:0], w[3][31:24]};
    assign temp = {sbox(rot[31:24]) ^ rcon_i, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

    // Each new word chains on the previous new word.
    assign n[0] = w[0] ^ temp;
    assign n[1] = w[1] ^ n[0];
    assign n[2] = w[2] ^ n[1];
    assign n[3] = w[3] ^ n[2];

endmodule

// File: rtl/round_tf.sv
// AES round transform without the round-key XOR (combinational).
//   b_i    : input state, byte 0 in [127:120], column-major
//   b_sr_o : SubBytes + ShiftRows (final-round form)
//   b_o    : full round (adds MixColumns when EN_MC=1)
module round_tf
    import aes_enc_ctrl_pkg::*;
#(
    parameter bit EN_MC = 1'b1
) (
    input  aes_state_t b_i,
    output aes_state_t b_o,
    output aes_state_t b_sr_o
);

    aes_state_t mc;

    genvar gi;
    generate
        // Byte 4c+r of the output takes row r from column (c+r) mod 4.
        for (gi = 0; gi < 16; gi++) begin : g_sub_shift
            localparam int COL = gi / 4;
            localparam int ROW = gi % 4;
            localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
            assign b_sr_o[127 - 8 * gi -: 8] = sbox(b_i[127 - 8 * SRC -: 8]);
        end

        for (gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = b_sr_o[127 - 32 * gi -: 8];
            assign a1 = b_sr_o[119 - 32 * gi -: 8];
            assign a2 = b_sr_o[111 - 32 * gi -: 8];
            assign a3 = b_sr_o[103 - 32 * gi -: 8];
            assign mc[127 - 32 * gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mc[119 - 32 * gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mc[111 - 32 * gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mc[103 - 32 * gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end

        if (EN_MC) begin : g_mc_on
            assign b_o = mc;
        end else begin : g_mc_off
            assign b_o = b_sr_o;
        end
    endgenerate

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryption sequencer: initial AddRoundKey at the input
// handshake, then one round per cycle with the key schedule computed on the fly.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : aes_enc_ctrl_if.slave (job in, ciphertext out, busy)
//   abort_i       : only with AES_ENC_CTRL_ABORT_EN defined; drops the job in
//                   ROUND/DONE and returns to IDLE
// Latency: handshake at cycle 0 -> out_valid_o at cycle NR+1.
module aes_enc_ctrl
    import aes_enc_ctrl_pkg::*;
#(
    parameter int         NR        = AES_NR,
    parameter aes_state_t RST_STATE = '0
) (
    input  logic clk_i,
    input  logic rst_ni,
`ifdef AES_ENC_CTRL_ABORT_EN
    input  logic abort_i,
`endif
    aes_enc_ctrl_if.slave bus
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    aes_ctrl_e  fsm_reg;
    aes_state_t state_reg;
    aes_state_t rkey_reg;
    logic [3:0] rnd_reg;
    aes_state_t ct_reg;
    logic       in_ready_reg;
    logic       out_valid_reg;
    logic       busy_reg;

    aes_state_t nkey;
    aes_state_t round_full;
    aes_state_t round_last;

    aes_key_step u_key_step (
        .rkey_i (rkey_reg),
        .rcon_i (rcon(rnd_reg)),
        .nkey_o (nkey)
    );

    round_tf #(.EN_MC(1'b1)) u_round_tf (
        .b_i    (state_reg),
        .b_o    (round_full),
        .b_sr_o (round_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_reg       <= IDLE;
            state_reg     <= RST_STATE;
            rkey_reg      <= RST_STATE;
            rnd_reg       <= 4'd0;
            ct_reg        <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    // in_ready_o is high throughout IDLE, so valid alone completes the handshake.
                    if (bus.in_valid_i) begin
                        state_reg    <= bus.pt_i ^ bus.key_i;
                        rkey_reg     <= bus.key_i;
                        rnd_reg      <= 4'd1;
                        fsm_reg      <= ROUND;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                ROUND: begin
                    rkey_reg <= nkey;
                    if (rnd_reg == LAST_RND) begin
                        state_reg     <= round_last ^ nkey;
                        ct_reg        <= round_last ^ nkey;
                        rnd_reg       <= 4'd0;
                        fsm_reg       <= DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        state_reg <= round_full ^ nkey;
                        rnd_reg   <= rnd_reg + 4'd1;
                    end
                end
                DONE: begin
                    // ct_reg is left alone so ct_o holds until the next result.
                    if (bus.out_ready_i) begin
                        fsm_reg       <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: fsm_reg <= IDLE;
            endcase
`ifdef AES_ENC_CTRL_ABORT_EN
            // Placed after the case so it overrides any transition above, including out_ready_i in DONE.
            if (abort_i && (fsm_reg != IDLE)) begin
                fsm_reg       <= IDLE;
                state_reg     <= RST_STATE;
                rkey_reg      <= RST_STATE;
                rnd_reg       <= 4'd0;
                in_ready_reg  <= 1'b1;
                out_valid_reg <= 1'b0;
                busy_reg      <= 1'b0;
            end
`endif
        end
    end

    assign bus.in_ready_o  = in_ready_reg;
    assign bus.out_valid_o = out_valid_reg;
    assign bus.ct_o        = ct_reg;
    assign bus.busy_o      = busy_reg;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Directed bench for aes_enc_ctrl: FIPS-197 vectors, latency, backpressure,
// ignored input during a job, mid-job reset and (with AES_ENC_CTRL_ABORT_EN) abort.
module tb_aes_enc_ctrl;
    import aes_enc_ctrl_pkg::*;

    localparam aes_state_t PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam aes_state_t KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_state_t CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam aes_state_t PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam aes_state_t KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_state_t CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    aes_enc_ctrl_if bus ();

`ifdef AES_ENC_CTRL_ABORT_EN
    logic abort;
`endif

    aes_enc_ctrl dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
`ifdef AES_ENC_CTRL_ABORT_EN
        .abort_i (abort),
`endif
        .bus     (bus.master)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-18s observed %h expected %h", tag, obs, exp);
    endtask

    // Present a job at the current negedge; returns one negedge after the handshake edge.
    task automatic start_job(input aes_state_t pt, input aes_state_t key, input string tag);
        check({tag, "_in_ready"}, 128'(bus.in_ready_o), 128'd1);
        bus.in_valid_i = 1'b1;
        bus.pt_i       = pt;
        bus.key_i      = key;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        check({tag, "_busy"}, 128'(bus.busy_o), 128'd1);
    endtask

    // Called one cycle after the handshake; waits (bounded) for out_valid_o.
    task automatic wait_result(input aes_state_t exp_ct, input string tag);
        int cyc = 1;
        while (!bus.out_valid_o && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 128'(cyc), 128'd11);
        check({tag, "_ct"}, bus.ct_o, exp_ct);
    endtask

    task automatic finish_job(input aes_state_t exp_ct, input string tag);
        @(negedge clk);
        check({tag, "_valid_drop"}, 128'(bus.out_valid_o), 128'd0);
        check({tag, "_ready_back"}, 128'(bus.in_ready_o), 128'd1);
        check({tag, "_ct_hold"}, bus.ct_o, exp_ct);
    endtask

    initial begin
        int seen;
        rst_n           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.pt_i        = '0;
        bus.key_i       = '0;
        bus.out_ready_i = 1'b1;
`ifdef AES_ENC_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready_o), 128'd1);
        check("rst_out_valid", 128'(bus.out_valid_o), 128'd0);
        check("rst_busy", 128'(bus.busy_o), 128'd0);
        check("rst_ct", bus.ct_o, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: FIPS-197 appendix B
        start_job(PT_B, KEY_B, "b");
        wait_result(CT_B, "b");
        finish_job(CT_B, "b");

        // 2: FIPS-197 C.1
        start_job(PT_C, KEY_C, "c1");
        wait_result(CT_C, "c1");
        finish_job(CT_C, "c1");

        // 3: backpressure in DONE
        bus.out_ready_i = 1'b0;
        start_job(PT_B, KEY_B, "bp");
        wait_result(CT_B, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 128'(bus.out_valid_o), 128'd1);
            check("bp_hold_ct", bus.ct_o, CT_B);
            check("bp_hold_in_ready", 128'(bus.in_ready_o), 128'd0);
        end
        bus.out_ready_i = 1'b1;
        finish_job(CT_B, "bp");

        // 4: in_valid_i held with changing pt_i during ROUND is ignored
        start_job(PT_C, KEY_C, "ign");
        bus.in_valid_i = 1'b1;
        seen = 1;
        while (!bus.out_valid_o && seen < 30) begin
            bus.pt_i  = {$urandom, $urandom, $urandom, $urandom};
            bus.key_i = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            seen++;
        end
        bus.in_valid_i = 1'b0;
        check("ign_latency", 128'(seen), 128'd11);
        check("ign_ct", bus.ct_o, CT_C);
        finish_job(CT_C, "ign");

        // 5: reset at round 5 (rnd=1 now, four more cycles)
        start_job(PT_C, KEY_C, "rst");
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(bus.out_valid_o), 128'd0);
        check("rst_mid_in_ready", 128'(bus.in_ready_o), 128'd1);
        check("rst_mid_busy", 128'(bus.busy_o), 128'd0);
        check("rst_mid_ct", bus.ct_o, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_job(PT_B, KEY_B, "post_rst");
        wait_result(CT_B, "post_rst");
        finish_job(CT_B, "post_rst");

`ifdef AES_ENC_CTRL_ABORT_EN
        // 6: abort at round 3
        start_job(PT_B, KEY_B, "abt");
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abt_in_ready", 128'(bus.in_ready_o), 128'd1);
        check("abt_busy", 128'(bus.busy_o), 128'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid_o) seen++;
            @(negedge clk);
        end
        check("abt_no_valid", 128'(seen), 128'd0);
        start_job(PT_C, KEY_C, "post_abt");
        wait_result(CT_C, "post_abt");
        finish_job(CT_C, "post_abt");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
